nios_mtl_onchip_ram_pipe: RTL and testbench

Parametrised single-port Avalon-MM on-chip RAM slave for the Nios MTL system. It is the pipelined successor of the fixed 32-bit x 5000-word on-chip memory and adds several features: configurable width, depth and read latency (1 or 2), read/readdatavalid/waitrequest handshaking, out-of-range address protection, and a hardware scrub engine that zero-fills the array after reset or on request. It sits on the system interconnect as program/data RAM behind the Nios CPU.

---
 rtl/nios_mtl_onchip_ram_pipe_if.sv | 26 ++
 rtl/nios_mtl_onchip_ram_pipe.sv | 149 ++++++++++++++
 tb/tb_nios_mtl_onchip_ram_pipe.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_mtl_onchip_ram_pipe_if.sv
// Avalon-MM bus bundle between the system interconnect and the pipelined on-chip RAM.
// The master modport is the interconnect side; the slave modport is the RAM side.
interface nios_mtl_onchip_ram_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/nios_mtl_onchip_ram_pipe.sv
// Pipelined single-port Avalon-MM on-chip RAM with byte lanes, range guard, 1/2-cycle
// read latency and a zero-fill scrub engine that runs after reset or on request.
module nios_mtl_onchip_ram_pipe #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 13,
  parameter int DEPTH          = 5000,
  parameter int READ_LATENCY   = 1,
  parameter int SCRUB_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  nios_mtl_onchip_ram_pipe_if.slave  bus,
  input  logic                       clken,
  input  logic                       reset_req,
  input  logic                       scrub_start,
  output logic                       scrub_busy
);
  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_SCRUB = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (SCRUB_ON_RESET != 0) ? ST_SCRUB : ST_READY;

  logic [DATA_W-1:0]       mem_r [DEPTH];
  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    pend_r;
  logic                    pend_nxt_s;
  logic [ADDR_W-1:0]       cnt_r;
  logic [ADDR_W-1:0]       cnt_nxt_s;
  logic                    busy_r;
  logic [READ_LATENCY-1:0] vld_r;
  logic [DATA_W-1:0]       dat_r [READ_LATENCY];

  logic                    en_s;
  logic                    inflight_s;
  logic                    in_range_s;
  logic [IDX_W-1:0]        idx_s;
  logic [DATA_W-1:0]       rd_word_s;
  logic                    wait_s;
  logic                    rd_acc_s;
  logic                    wr_acc_s;
  logic                    scrub_we_s;

  assign en_s       = clken & ~reset_req;
  assign inflight_s = |vld_r;
  assign in_range_s = ({1'b0, bus.address} < DEPTH_EXT);
  assign idx_s      = bus.address[IDX_W-1:0];
  assign rd_word_s  = in_range_s ? mem_r[idx_s] : {DATA_W{1'b0}};
  assign scrub_busy = busy_r;

  // FSM state, scrub counter, pending-scrub flag and busy flag; frozen while en is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RESET_STATE;
      pend_r  <= 1'b0;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= (RESET_STATE == ST_SCRUB);
    end else if (en_s) begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_SCRUB);
    end
  end

  // Next-state logic: a requested scrub waits for the read pipeline to drain
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_SCRUB: begin
        if (cnt_r == LAST_IDX) begin
          cnt_nxt_s   = {ADDR_W{1'b0}};
          state_nxt_s = ST_READY;
        end else begin
          cnt_nxt_s   = cnt_r + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if ((scrub_start || pend_r) && !inflight_s) begin
          state_nxt_s = ST_SCRUB;
          pend_nxt_s  = 1'b0;
        end else if (scrub_start) begin
          pend_nxt_s  = 1'b1;
        end else begin
          pend_nxt_s  = pend_r;
        end
      end
      default: begin
        state_nxt_s = RESET_STATE;
        pend_nxt_s  = 1'b0;
        cnt_nxt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Handshake and output decode; a parked result is masked, not dropped, while en is low
  always_comb begin
    wait_s            = (state_r == ST_SCRUB) | ~en_s | pend_r;
    rd_acc_s          = bus.chipselect & ~wait_s & bus.read & ~bus.write;
    wr_acc_s          = bus.chipselect & ~wait_s & bus.write & reset_n;
    scrub_we_s        = (state_r == ST_SCRUB) & en_s & reset_n;
    bus.waitrequest   = wait_s;
    bus.readdatavalid = vld_r[READ_LATENCY-1] & en_s;
    if (bus.readdatavalid) begin
      bus.readdata = dat_r[READ_LATENCY-1];
    end else begin
      bus.readdata = {DATA_W{1'b0}};
    end
  end

  // Read pipeline: stage 0 samples the array, later stages shift on enabled edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_r <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_r[i] <= {DATA_W{1'b0}};
      end
    end else if (en_s) begin
      vld_r[0] <= rd_acc_s;
      dat_r[0] <= rd_word_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  // Storage array, deliberately without reset; the scrub engine owns it while active
  always_ff @(posedge clk) begin
    if (scrub_we_s) begin
      mem_r[cnt_r[IDX_W-1:0]] <= {DATA_W{1'b0}};
    end else if (wr_acc_s && in_range_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.byteenable[i]) begin
          mem_r[idx_s][i*8 +: 8] <= bus.writedata[i*8 +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_nios_mtl_onchip_ram_pipe.sv
// Drives a latency-1 and a latency-2 RAM with identical stimulus and checks each
// against its own transaction-level reference model every cycle.
module tb_nios_mtl_onchip_ram_pipe;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic          clken;
  logic          reset_req;
  logic          scrub_start;
  logic          busy1;
  logic          busy2;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = latency 1, index 1 = latency 2
  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] rsp_d   [2][4];
  int          rsp_age [2][4];
  int          rsp_n   [2];
  int          scrub_left [2];
  bit          pend    [2];
  int          nstrobe [2];
  logic [31:0] last_rd [2];

  nios_mtl_onchip_ram_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  nios_mtl_onchip_ram_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  assign bus1.address    = address;
  assign bus1.byteenable = byteenable;
  assign bus1.chipselect = chipselect;
  assign bus1.read       = read;
  assign bus1.write      = write;
  assign bus1.writedata  = writedata;
  assign bus2.address    = address;
  assign bus2.byteenable = byteenable;
  assign bus2.chipselect = chipselect;
  assign bus2.read       = read;
  assign bus2.write      = write;
  assign bus2.writedata  = writedata;

  nios_mtl_onchip_ram_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
                             .READ_LATENCY(1), .SCRUB_ON_RESET(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .clken(clken),
    .reset_req(reset_req), .scrub_start(scrub_start), .scrub_busy(busy1)
  );

  nios_mtl_onchip_ram_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
                             .READ_LATENCY(2), .SCRUB_ON_RESET(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .clken(clken),
    .reset_req(reset_req), .scrub_start(scrub_start), .scrub_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rsp_n[k]      = 0;
      pend[k]       = 1'b0;
      scrub_left[k] = DEPTH;
      for (int a = 0; a < DEPTH; a++) ref_mem[k][a] = 32'h0;
    end
  endtask

  // expected outputs for the current cycle, compared at the falling edge
  task automatic check_all();
    logic [31:0] o_rd [2];
    logic        o_rdv [2];
    logic        o_wr [2];
    logic        o_busy [2];
    logic        en;
    logic        e_rdv;
    logic [31:0] e_rd;
    o_rd[0] = bus1.readdata;  o_rdv[0] = bus1.readdatavalid;
    o_wr[0] = bus1.waitrequest; o_busy[0] = busy1;
    o_rd[1] = bus2.readdata;  o_rdv[1] = bus2.readdatavalid;
    o_wr[1] = bus2.waitrequest; o_busy[1] = busy2;
    en = clken & ~reset_req;
    for (int k = 0; k < 2; k++) begin
      e_rdv = (reset_n === 1'b1) && (rsp_n[k] > 0) && (rsp_age[k][0] == k + 1) && en;
      e_rd  = e_rdv ? rsp_d[k][0] : 32'h0;
      chk($sformatf("readdatavalid_L%0d", k + 1), {31'h0, o_rdv[k]}, {31'h0, e_rdv});
      chk($sformatf("readdata_L%0d", k + 1), o_rd[k], e_rd);
      chk($sformatf("waitrequest_L%0d", k + 1), {31'h0, o_wr[k]},
          {31'h0, (scrub_left[k] > 0) || !en || pend[k]});
      chk($sformatf("scrub_busy_L%0d", k + 1), {31'h0, o_busy[k]},
          {31'h0, scrub_left[k] > 0});
      if (o_rdv[k] === 1'b1) begin
        nstrobe[k]++;
        last_rd[k] = o_rd[k];
      end
    end
  endtask

  // reference update for one rising edge, using the inputs held during the cycle
  task automatic model_edge();
    logic en;
    bit   acc;
    bit   inflight;
    int   idx;
    en  = clken & ~reset_req;
    idx = int'(address);
    if (reset_n !== 1'b1 || !en) return;
    for (int k = 0; k < 2; k++) begin
      acc      = chipselect && !((scrub_left[k] > 0) || pend[k]);
      inflight = rsp_n[k] > 0;
      if (rsp_n[k] > 0 && rsp_age[k][0] == k + 1) begin
        for (int j = 0; j < 3; j++) begin
          rsp_d[k][j]   = rsp_d[k][j+1];
          rsp_age[k][j] = rsp_age[k][j+1];
        end
        rsp_n[k]--;
      end
      for (int j = 0; j < rsp_n[k]; j++) rsp_age[k][j]++;
      if (acc && read && !write) begin
        rsp_d[k][rsp_n[k]]   = (idx < DEPTH) ? ref_mem[k][idx] : 32'h0;
        rsp_age[k][rsp_n[k]] = 1;
        rsp_n[k]++;
      end
      if (acc && write && idx < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) ref_mem[k][idx][8*b +: 8] = writedata[8*b +: 8];
      end
      if (scrub_left[k] > 0) begin
        scrub_left[k]--;
      end else if ((scrub_start || pend[k]) && !inflight) begin
        scrub_left[k] = DEPTH;
        pend[k]       = 1'b0;
        for (int a = 0; a < DEPTH; a++) ref_mem[k][a] = 32'h0;
      end else if (scrub_start) begin
        pend[k] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0; scrub_start = 1'b0;
    clken = 1'b1; reset_req = 1'b0; byteenable = 4'h0; address = '0; writedata = 32'h0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = AW'(a); writedata = d; byteenable = be;
    cycle();
    idle();
  endtask

  task automatic rd(input int a);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = AW'(a);
    cycle();
    idle();
  endtask

  task automatic reset_now();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rdv_L1", {31'h0, bus1.readdatavalid}, 32'h0);
    chk("rst_rdv_L2", {31'h0, bus2.readdatavalid}, 32'h0);
    chk("rst_rdata_L1", bus1.readdata, 32'h0);
    chk("rst_rdata_L2", bus2.readdata, 32'h0);
    chk("rst_busy_L1", {31'h0, busy1}, 32'h1);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (DEPTH + 2) cycle();

    // every word reads back zero after the power-on scrub
    for (int a = 0; a < DEPTH; a++) begin
      chipselect = 1'b1; read = 1'b1; address = AW'(a);
      cycle();
    end
    idle();
    repeat (3) cycle();

    // byte-lane merge
    wr(5, 32'hDEADBEEF, 4'hF);
    wr(5, 32'h000000AA, 4'h1);
    rd(5);
    repeat (3) cycle();
    chk("merge_L1", last_rd[0], 32'hDEADBEAA);
    chk("merge_L2", last_rd[1], 32'hDEADBEAA);

    // burst of 8 reads with a 3-cycle clock-enable gap
    for (int a = 0; a < 8; a++) wr(a, 32'h1000 + 32'(a), 4'hF);
    nstrobe[0] = 0; nstrobe[1] = 0;
    for (int a = 0; a < 8; a++) begin
      chipselect = 1'b1; read = 1'b1; address = AW'(a);
      if (a == 4) begin
        clken = 1'b0;
        repeat (3) cycle();
        clken = 1'b1;
      end
      cycle();
    end
    idle();
    repeat (4) cycle();
    chk("burst_cnt_L1", 32'(nstrobe[0]), 32'd8);
    chk("burst_cnt_L2", 32'(nstrobe[1]), 32'd8);
    chk("burst_last_L1", last_rd[0], 32'h1007);
    chk("burst_last_L2", last_rd[1], 32'h1007);

    // out-of-range write is dropped, out-of-range read returns zero once
    wr(20, 32'h12345678, 4'hF);
    last_rd[0] = 32'hFFFFFFFF; last_rd[1] = 32'hFFFFFFFF;
    nstrobe[0] = 0; nstrobe[1] = 0;
    rd(20);
    repeat (3) cycle();
    chk("oor_rd_L1", last_rd[0], 32'h0);
    chk("oor_rd_L2", last_rd[1], 32'h0);
    chk("oor_cnt_L2", 32'(nstrobe[1]), 32'd1);
    rd(4);
    repeat (3) cycle();
    chk("oor_alias_L2", last_rd[1], 32'h1004);

    // scrub requested with two reads in flight
    chipselect = 1'b1; read = 1'b1; address = AW'(5);
    cycle();
    address = AW'(6);
    cycle();
    idle();
    scrub_start = 1'b1;
    cycle();
    scrub_start = 1'b0;
    repeat (DEPTH + 6) cycle();
    rd(5);
    repeat (3) cycle();
    chk("post_scrub_L1", last_rd[0], 32'h0);
    chk("post_scrub_L2", last_rd[1], 32'h0);

    // reset seven words into a scrub, then reset with a read in flight
    scrub_start = 1'b1;
    cycle();
    scrub_start = 1'b0;
    repeat (7) cycle();
    reset_now();
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (DEPTH + 2) cycle();
    wr(3, 32'hCAFEF00D, 4'hF);
    rd(3);
    nstrobe[0] = 0; nstrobe[1] = 0;
    reset_now();
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (DEPTH + 4) cycle();
    chk("no_stale_L1", 32'(nstrobe[0]), 32'd0);
    chk("no_stale_L2", 32'(nstrobe[1]), 32'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      chipselect  = ($urandom_range(0, 3) != 0);
      read        = 1'($urandom_range(0, 1));
      write       = ($urandom_range(0, 2) == 0);
      address     = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(16, 31))
                                                 : AW'($urandom_range(0, 15));
      byteenable  = 4'($urandom_range(0, 15));
      writedata   = $urandom;
      clken       = ($urandom_range(0, 9) != 0);
      reset_req   = ($urandom_range(0, 19) == 0);
      scrub_start = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset_now();
        cycle();
        reset_n = 1'b1;
      end
      cycle();
    end
    idle();
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
